mmio_bus_ctrl: RTL and testbench

- Parametrised memory-mapped bus controller between the multi-cycle MIPS32 core and its NSLV peripherals (ROM, SRAM, output port, future devices).
- Replaces the fixed 3-to-8 chip-select decode with a registered transaction FSM.
- Adds per-slave programmable wait states, a one-cycle write strobe, registered read data, a ready handshake and an error response for unmapped or illegal accesses.

---
 rtl/mmio_pkg.sv | 23 ++
 rtl/mmio_addr_decode.sv | 34 +++
 rtl/mmio_bus_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// ---------------------------------------------------------------------------
// mmio_pkg
// Shared definitions for the MIPS32 memory-mapped bus controller:
//   - transaction FSM state encoding
//   - default slave region numbers (ROM, SRAM, output port)
//   - default position/width of the region-select field in the address
// ---------------------------------------------------------------------------
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int unsigned REGION_ROM  = 0;
    localparam int unsigned REGION_RAM  = 1;
    localparam int unsigned REGION_OUT  = 2;

    localparam int unsigned SEL_LSB_DEF = 11;
    localparam int unsigned SEL_W_DEF   = 3;

endpackage

// File: rtl/mmio_addr_decode.sv
// ---------------------------------------------------------------------------
// mmio_addr_decode
// Combinational region decoder. The caller slices the region-select field
// out of the address, so the decoder sees only the bits it needs.
// Ports:
//   sel_i    in   SEL_W  region-select field of the address
//   idx_o    out  SEL_W  region index
//   valid_o  out  1      index maps to an implemented slave (idx < NSLV)
//   nce_o    out  NSLV   active-low one-hot chip selects (all 1 if invalid)
// ---------------------------------------------------------------------------
module mmio_addr_decode
#(
    parameter int unsigned NSLV  = 3,
    parameter int unsigned SEL_W = 3
)(
    input  logic [SEL_W-1:0] sel_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             valid_o,
    output logic [NSLV-1:0]  nce_o
);

    assign idx_o   = sel_i;
    assign valid_o = (32'(sel_i) < NSLV);

    always_comb begin
        nce_o = '1;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (sel_i == SEL_W'(i)) begin
                nce_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_bus_ctrl
// Registered bus controller between the multi-cycle MIPS32 core and NSLV
// memory-mapped slaves. IDLE latches a request, ACCESS holds the chip select
// for WAITS[idx]+1 cycles (write strobe only in the final one), DONE returns
// a one-cycle m_ready with m_err for unmapped or read+write requests.
// Optional feature macro: MMIO_ERR_CAPTURE_EN (sticky err_flag + err_addr).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   m_re, m_we         master read / write request (held until m_ready)
//   m_addr, m_wdata    master address / write data
//   m_rdata            registered read data, valid with m_ready
//   m_ready, m_err     completion pulse and error qualifier
//   s_nce              active-low chip selects, at most one low
//   s_re, s_we         slave read strobe (whole access), write strobe (last cycle)
//   s_addr, s_wdata    latched address / write data to slaves
//   s_rdata            packed slave read buses, slave i at [i*DW +: DW]
//   err_addr, err_flag last faulting address, sticky error flag
// ---------------------------------------------------------------------------
module mmio_bus_ctrl
    import mmio_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned NSLV    = 3,
    parameter int unsigned SEL_LSB = SEL_LSB_DEF,
    parameter int unsigned SEL_W   = SEL_W_DEF,
    parameter int unsigned WAIT_W  = 4,
    parameter logic [NSLV*WAIT_W-1:0] WAITS = '0
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               m_re,
    input  logic               m_we,
    input  logic [AW-1:0]      m_addr,
    input  logic [DW-1:0]      m_wdata,
    output logic [DW-1:0]      m_rdata,
    output logic               m_ready,
    output logic               m_err,
    output logic [NSLV-1:0]    s_nce,
    output logic               s_re,
    output logic               s_we,
    output logic [AW-1:0]      s_addr,
    output logic [DW-1:0]      s_wdata,
    input  logic [NSLV*DW-1:0] s_rdata,
    output logic [AW-1:0]      err_addr,
    output logic               err_flag
);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [NSLV-1:0]     nce_q, nce_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [DW-1:0]       rdata_q, rdata_d;

    logic [SEL_W-1:0]    dec_idx;
    logic                dec_valid;
    logic [NSLV-1:0]     dec_nce;
    logic [WAIT_W-1:0]   wait_sel;
    logic [DW-1:0]       rd_sel;

    mmio_addr_decode #(
        .NSLV  (NSLV),
        .SEL_W (SEL_W)
    ) u_decode (
        .sel_i   (m_addr[SEL_LSB +: SEL_W]),
        .idx_o   (dec_idx),
        .valid_o (dec_valid),
        .nce_o   (dec_nce)
    );

    // Wait count for the region addressed by the incoming request.
    always_comb begin
        wait_sel = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (dec_idx == SEL_W'(i)) begin
                wait_sel = WAITS[i*WAIT_W +: WAIT_W];
            end
        end
    end

    // Read bus of the slave latched for the current access.
    always_comb begin
        rd_sel = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (idx_q == SEL_W'(i)) begin
                rd_sel = s_rdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            nce_q   <= '1;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nce_q   <= nce_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nce_d   = nce_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (m_re | m_we) begin
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    idx_d   = dec_idx;
                    wr_d    = m_we;
                    cnt_d   = wait_sel;
                    if (dec_valid && (m_re ^ m_we)) begin
                        nce_d   = dec_nce;
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end else begin
                        nce_d   = '1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end
                end
            end
            ACCESS: begin
                // Counting down to zero gives WAITS+1 access cycles without
                // needing an extra counter bit for the maximum wait value.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    rdata_d = wr_q ? '0 : rd_sel;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_nce   = (state_q == ACCESS) ? nce_q : '1;
    assign s_re    = (state_q == ACCESS) && !wr_q;
    assign s_we    = (state_q == ACCESS) && wr_q && (cnt_q == '0);
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign m_ready = (state_q == DONE);
    assign m_err   = (state_q == DONE) && err_q;
    assign m_rdata = rdata_q;

`ifdef MMIO_ERR_CAPTURE_EN
    logic [AW-1:0] err_addr_q;
    logic          err_flag_q;

    // Only the error path goes straight from IDLE to DONE, so capture on
    // that transition; the faulting address is visible together with m_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_addr_q <= '0;
            err_flag_q <= 1'b0;
        end else if ((state_q == IDLE) && (state_d == DONE)) begin
            err_addr_q <= m_addr;
            err_flag_q <= 1'b1;
        end
    end

    assign err_addr = err_addr_q;
    assign err_flag = err_flag_q;
`else
    assign err_addr = '0;
    assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
module tb_mmio_bus_ctrl;
    import mmio_pkg::*;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned NSLV   = 3;
    localparam int unsigned WAIT_W = 4;
    localparam logic [NSLV*WAIT_W-1:0] WAITS_CFG = {4'd3, 4'd0, 4'd0};

    localparam logic [31:0] RD0 = 32'h1111_0000;
    localparam logic [31:0] RD1 = 32'hDEAD_BEEF;
    localparam logic [31:0] RD2 = 32'h2222_2222;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                m_re = 1'b0;
    logic                m_we = 1'b0;
    logic [AW-1:0]       m_addr = '0;
    logic [DW-1:0]       m_wdata = '0;
    logic [DW-1:0]       m_rdata;
    logic                m_ready;
    logic                m_err;
    logic [NSLV-1:0]     s_nce;
    logic                s_re;
    logic                s_we;
    logic [AW-1:0]       s_addr;
    logic [DW-1:0]       s_wdata;
    logic [NSLV*DW-1:0]  s_rdata;
    logic [AW-1:0]       err_addr;
    logic                err_flag;

    assign s_rdata = {RD2, RD1, RD0};

    mmio_bus_ctrl #(
        .AW     (AW),
        .DW     (DW),
        .NSLV   (NSLV),
        .SEL_LSB(11),
        .SEL_W  (3),
        .WAIT_W (WAIT_W),
        .WAITS  (WAITS_CFG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_re     (m_re),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .s_nce    (s_nce),
        .s_re     (s_re),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata),
        .err_addr (err_addr),
        .err_flag (err_flag)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned rcyc;
        logic [2:0]  lowmask;
        int unsigned ncnt;
        int unsigned recnt;
        int unsigned wecnt;
        logic [31:0] wdata;
        logic [31:0] waddr;
        logic [31:0] eaddr;
        logic        eflag;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int unsigned ready_total = 0;
    int unsigned we_total = 0;

    logic [31:0] eaddr_m = '0;
    logic        eflag_m = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: accumulates strobe activity per transaction, compares at m_ready.
    initial begin
        int unsigned ncnt, recnt, wecnt, we_cyc;
        logic [2:0]  lowmask;
        logic [31:0] we_data, we_addr;
        exp_t        e;
        ncnt = 0; recnt = 0; wecnt = 0; we_cyc = 0;
        lowmask = '0; we_data = '0; we_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ncnt = 0; recnt = 0; wecnt = 0; lowmask = '0;
            end else begin
                if (s_nce != 3'b111) begin
                    chk("nce_at_most_one_low", 64'($countones(~s_nce) <= 1), 64'd1);
                    ncnt++;
                    lowmask = lowmask | ~s_nce;
                end
                if (s_re) recnt++;
                if (s_we) begin
                    wecnt++;
                    we_total++;
                    we_cyc  = cyc;
                    we_data = s_wdata;
                    we_addr = s_addr;
                end
                if (m_ready) begin
                    ready_total++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: m_ready=1 with no pending transaction (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("m_rdata",   m_rdata, e.rdata);
                        chk("m_err",     m_err, e.err);
                        chk("ready_cyc", cyc, e.rcyc);
                        chk("nce_mask",  lowmask, e.lowmask);
                        chk("nce_cycles", ncnt, e.ncnt);
                        chk("re_cycles", recnt, e.recnt);
                        chk("we_cycles", wecnt, e.wecnt);
                        chk("err_addr",  err_addr, e.eaddr);
                        chk("err_flag",  err_flag, e.eflag);
                        if (e.wecnt == 1 && wecnt == 1) begin
                            chk("we_last_cycle", we_cyc, e.rcyc - 1);
                            chk("we_data", we_data, e.wdata);
                            chk("we_addr", we_addr, e.waddr);
                        end
                    end
                    ncnt = 0; recnt = 0; wecnt = 0; lowmask = '0;
                end
            end
        end
    end

    task automatic push_exp(input logic re, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] erdata,
                            input logic eerr, input int unsigned waits,
                            input logic [2:0] emask, input int unsigned rcyc);
        exp_t e;
`ifdef MMIO_ERR_CAPTURE_EN
        if (eerr) begin
            eaddr_m = addr;
            eflag_m = 1'b1;
        end
`endif
        e.rdata   = erdata;
        e.err     = eerr;
        e.rcyc    = rcyc;
        e.lowmask = emask;
        e.ncnt    = eerr ? 0 : waits + 1;
        e.recnt   = (!eerr && re) ? waits + 1 : 0;
        e.wecnt   = (!eerr && we) ? 1 : 0;
        e.wdata   = wdata;
        e.waddr   = addr;
        e.eaddr   = eaddr_m;
        e.eflag   = eflag_m;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input logic scramble);
        int unsigned n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (scramble && n == 1) begin
                m_addr  = 32'h0000_3800;
                m_wdata = 32'hFFFF_FFFF;
            end
        end while (!m_ready && n < 40);
        if (!m_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: no m_ready within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    // Called at a negedge with the controller idle; returns at the m_ready negedge.
    task automatic run_txn(input logic re, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] erdata,
                           input logic eerr, input int unsigned waits,
                           input logic [2:0] emask, input logic scramble);
        m_re    = re;
        m_we    = we;
        m_addr  = addr;
        m_wdata = wdata;
        push_exp(re, we, addr, wdata, erdata, eerr, waits, emask,
                 eerr ? cyc + 1 : cyc + waits + 2);
        wait_ready(scramble);
        m_re = 1'b0;
        m_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a_rom, a_ram, a_out;
        int unsigned r0, w0;
        a_rom = 32'(REGION_ROM) << 11;
        a_ram = 32'(REGION_RAM) << 11;
        a_out = 32'(REGION_OUT) << 11;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_s_nce",   s_nce, 3'b111);
        chk("rst_s_re",    s_re, 1'b0);
        chk("rst_s_we",    s_we, 1'b0);
        chk("rst_m_ready", m_ready, 1'b0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_err_flag", err_flag, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Read 0x804 (region 1, zero waits)
        run_txn(1'b1, 1'b0, a_ram | 32'h4, 32'h0, RD1, 1'b0, 0, 3'b010, 1'b0);
        @(negedge clk);
        // Write 0x1000 (region 2, 3 waits); inputs scrambled mid-transfer
        run_txn(1'b0, 1'b1, a_out, 32'h0000_03FF, 32'h0, 1'b0, 3, 3'b100, 1'b1);
        @(negedge clk);
        // Unmapped region 7
        run_txn(1'b1, 1'b0, 32'h0000_3800, 32'h0, 32'h0, 1'b1, 0, 3'b000, 1'b0);
        @(negedge clk);
        // Simultaneous read and write
        run_txn(1'b1, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0, 1'b1, 0, 3'b000, 1'b0);
        @(negedge clk);
        // Read region 2 with 3 waits
        run_txn(1'b1, 1'b0, a_out | 32'h10, 32'h0, RD2, 1'b0, 3, 3'b100, 1'b0);
        @(negedge clk);
        // Write region 0, zero waits: strobe on the only access cycle
        run_txn(1'b0, 1'b1, a_rom | 32'h8, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 3'b001, 1'b0);
        @(negedge clk);

        // Back-to-back reads with m_re held: region 0 then region 1
        m_re   = 1'b1;
        m_addr = a_rom;
        push_exp(1'b1, 1'b0, a_rom, 32'h0, RD0, 1'b0, 0, 3'b001, cyc + 2);
        wait_ready(1'b0);
        m_addr = a_ram | 32'h4;
        push_exp(1'b1, 1'b0, a_ram | 32'h4, 32'h0, RD1, 1'b0, 0, 3'b010, cyc + 3);
        wait_ready(1'b0);
        m_re = 1'b0;
        @(negedge clk);

        // Reset during the 2nd access cycle of a 3-wait write
        r0 = ready_total;
        w0 = we_total;
        m_we    = 1'b1;
        m_addr  = a_out;
        m_wdata = 32'h0000_ABCD;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b1;
        m_we = 1'b0;
        @(negedge clk);
        chk("abort_s_nce",   s_nce, 3'b111);
        chk("abort_s_we",    s_we, 1'b0);
        chk("abort_s_re",    s_re, 1'b0);
        chk("abort_m_ready", m_ready, 1'b0);
        chk("abort_s_addr",  s_addr, 32'h0);
        chk("abort_s_wdata", s_wdata, 32'h0);
        chk("abort_m_rdata", m_rdata, 32'h0);
        chk("abort_err_flag", err_flag, 1'b0);
        chk("abort_err_addr", err_addr, 32'h0);
        eaddr_m = '0;
        eflag_m = 1'b0;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_we",    we_total, w0);
        chk("abort_no_ready", ready_total, r0);

        // Recovery after reset
        run_txn(1'b1, 1'b0, a_rom, 32'h0, RD0, 1'b0, 0, 3'b001, 1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
